sram_load_scheduler: RTL and testbench

Sequences one convolution/GEMM job around the AXI-Stream loader. It owns the shared single-ported SRAM command port, which carries loader writes for image then kernel and compute-engine reads. It latches the tensor configuration, checks received element counts against the declared dimensions, and issues a one-cycle start pulse to the GEMM engine. It sits between `axi_stream_input` and the SRAM bank array / GEMM controller.

---
 rtl/sram_load_scheduler_pkg.sv | 28 ++
 rtl/sram_load_scheduler_size_check.sv | 42 ++++
 rtl/sram_load_scheduler.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_sram_load_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_load_scheduler_pkg.sv
// Shared definitions for the SRAM load scheduler: job-phase encodings,
// SRAM bank selector indices and the width of the size-check products.
package sram_load_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_IMG = 3'd1,
    ST_LOAD_KER = 3'd2,
    ST_START    = 3'd3,
    ST_COMPUTE  = 3'd4
  } state_t;

  // Bank selectors carried on in_data_type / cmp_rd_sel / sram_sel.
  localparam logic [2:0] GEMM0_SRAM_IDX = 3'd0;  // image bank
  localparam logic [2:0] GEMM1_SRAM_IDX = 3'd1;  // kernel bank

  localparam int DEF_ADDR_WIDTH         = 13;
  localparam int DEF_DATA_WIDTH         = 8;
  localparam int DEF_NUM_CHANNELS_WIDTH = $clog2(64 + 1);

  // row * col * channels never overflows this width.
  function automatic int prod_width(input int addr_w, input int chan_w);
    return 2 * addr_w + chan_w;
  endfunction

  localparam int PROD_WIDTH = 2 * DEF_ADDR_WIDTH + DEF_NUM_CHANNELS_WIDTH;

endpackage

// File: rtl/sram_load_scheduler_size_check.sv
// Registered comparator: element count received vs. row*col*channels.
// The mismatch bit is loaded on 'check', cleared on 'clr' and otherwise held.
module tensor_size_check
  import sram_load_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
  parameter int NUM_CHANNELS_WIDTH = DEF_NUM_CHANNELS_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          check,
  input  logic [ADDR_WIDTH:0]           count,
  input  logic [ADDR_WIDTH-1:0]         dim_row,
  input  logic [ADDR_WIDTH-1:0]         dim_col,
  input  logic [NUM_CHANNELS_WIDTH-1:0] num_channels,
  output logic                          mismatch
);

  localparam int PW = prod_width(ADDR_WIDTH, NUM_CHANNELS_WIDTH);

  logic [PW-1:0] product;
  logic [PW-1:0] count_ext;

  // Zero-extend every operand so the product is exact.
  always_comb begin
    product   = PW'(dim_row) * PW'(dim_col) * PW'(num_channels);
    count_ext = PW'(count);
  end

  // Capture the comparison result; a new job clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch <= 1'b0;
    end else if (clr) begin
      mismatch <= 1'b0;
    end else if (check) begin
      mismatch <= (product != count_ext);
    end
  end

endmodule

// File: rtl/sram_load_scheduler.sv
// Job sequencer around the AXI-Stream loader. Owns the single SRAM command
// port: loader writes (image, then kernel) during the load phases and
// compute-engine reads during COMPUTE. Latches tensor dimensions, checks the
// element counts and pulses start_compute once per job.
module sram_load_scheduler
  import sram_load_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int NUM_CHANNELS_WIDTH = DEF_NUM_CHANNELS_WIDTH
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_areset,
  // loader write beat
  input  logic                          in_write_enable,
  input  logic                          in_last,
  input  logic [ADDR_WIDTH-1:0]         in_write_address,
  input  logic signed [DATA_WIDTH-1:0]  in_write_data,
  input  logic [2:0]                    in_data_type,
  // loader dimensions
  input  logic [ADDR_WIDTH-1:0]         in_img_row,
  input  logic [ADDR_WIDTH-1:0]         in_img_col,
  input  logic [ADDR_WIDTH-1:0]         in_ker_row,
  input  logic [ADDR_WIDTH-1:0]         in_ker_col,
  input  logic [NUM_CHANNELS_WIDTH-1:0] in_num_channels,
  // compute-side requests
  input  logic                          cmp_rd_req,
  input  logic [2:0]                    cmp_rd_sel,
  input  logic [ADDR_WIDTH-1:0]         cmp_rd_addr,
  input  logic                          cmp_done,
  output logic                          cmp_rd_gnt,
  // SRAM command port
  output logic                          sram_en,
  output logic                          sram_we,
  output logic [2:0]                    sram_sel,
  output logic [ADDR_WIDTH-1:0]         sram_addr,
  output logic signed [DATA_WIDTH-1:0]  sram_wdata,
  // job control / status
  output logic                          start_compute,
  output logic                          busy,
  output logic [ADDR_WIDTH-1:0]         cfg_img_row,
  output logic [ADDR_WIDTH-1:0]         cfg_img_col,
  output logic [ADDR_WIDTH-1:0]         cfg_ker_row,
  output logic [ADDR_WIDTH-1:0]         cfg_ker_col,
  output logic [NUM_CHANNELS_WIDTH-1:0] cfg_num_channels,
  output logic                          err_size,
  output logic                          err_overflow
);

  localparam logic [ADDR_WIDTH:0] CNT_SAT  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] CNT_ZERO = '0;

  logic clk;
  logic rst;
  assign clk = s_axis_aclk;
  assign rst = s_axis_areset;

  state_t state;
  state_t state_next;

  // per-cycle decode of what the current beat/request does
  logic wr_fire_p0;
  logic rd_fire_p0;
  logic wr_drop_p0;
  logic job_start_p0;
  logic img_beat_p0;
  logic ker_beat_p0;
  logic img_cfg_load_p0;
  logic ker_cfg_load_p0;
  logic size_check_p0;

  logic [ADDR_WIDTH:0] img_cnt;
  logic [ADDR_WIDTH:0] ker_cnt;

  logic img_mismatch;
  logic ker_mismatch;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a job runs image load, kernel load, one START cycle, compute.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (in_write_enable) begin
          state_next = in_last ? ST_LOAD_KER : ST_LOAD_IMG;
        end
      end
      ST_LOAD_IMG: begin
        if (in_write_enable && in_last) begin
          state_next = ST_LOAD_KER;
        end
      end
      ST_LOAD_KER: begin
        if (in_write_enable && in_last) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        state_next = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (cmp_done) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode: writes only in load phases, reads only in COMPUTE,
  // so the SRAM port never sees both in one cycle.
  always_comb begin
    wr_fire_p0      = 1'b0;
    rd_fire_p0      = 1'b0;
    wr_drop_p0      = 1'b0;
    job_start_p0    = 1'b0;
    img_beat_p0     = 1'b0;
    ker_beat_p0     = 1'b0;
    img_cfg_load_p0 = 1'b0;
    ker_cfg_load_p0 = 1'b0;
    size_check_p0   = 1'b0;
    busy            = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        wr_fire_p0      = in_write_enable;
        job_start_p0    = in_write_enable;
        img_cfg_load_p0 = in_write_enable && in_last;
      end
      ST_LOAD_IMG: begin
        wr_fire_p0      = in_write_enable;
        img_beat_p0     = in_write_enable;
        img_cfg_load_p0 = in_write_enable && in_last;
      end
      ST_LOAD_KER: begin
        wr_fire_p0      = in_write_enable;
        ker_beat_p0     = in_write_enable;
        ker_cfg_load_p0 = in_write_enable && in_last;
      end
      ST_START: begin
        wr_drop_p0    = in_write_enable;
        size_check_p0 = 1'b1;
      end
      ST_COMPUTE: begin
        wr_drop_p0 = in_write_enable;
        rd_fire_p0 = cmp_rd_req;
      end
      default: begin
      end
    endcase
  end

  // ---- stage p0 -> p1: SRAM command register ----
  // Issue the accepted write or read one cycle after it is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      cmp_rd_gnt <= 1'b0;
      sram_sel   <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      sram_en    <= wr_fire_p0 || rd_fire_p0;
      sram_we    <= wr_fire_p0;
      cmp_rd_gnt <= rd_fire_p0;
      if (wr_fire_p0) begin
        sram_sel   <= in_data_type;
        sram_addr  <= in_write_address;
        sram_wdata <= in_write_data;
      end else if (rd_fire_p0) begin
        sram_sel  <= cmp_rd_sel;
        sram_addr <= cmp_rd_addr;
      end
    end
  end

  // Element counters; the job's first beat is image element 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_cnt <= CNT_ZERO;
      ker_cnt <= CNT_ZERO;
    end else if (job_start_p0) begin
      img_cnt <= CNT_ONE;
      ker_cnt <= CNT_ZERO;
    end else begin
      if (img_beat_p0 && (img_cnt != CNT_SAT)) begin
        img_cnt <= img_cnt + CNT_ONE;
      end
      if (ker_beat_p0 && (ker_cnt != CNT_SAT)) begin
        ker_cnt <= ker_cnt + CNT_ONE;
      end
    end
  end

  // Latch dimensions on each tensor's last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_img_row      <= '0;
      cfg_img_col      <= '0;
      cfg_ker_row      <= '0;
      cfg_ker_col      <= '0;
      cfg_num_channels <= '0;
    end else begin
      if (img_cfg_load_p0) begin
        cfg_img_row <= in_img_row;
        cfg_img_col <= in_img_col;
      end
      if (ker_cfg_load_p0) begin
        cfg_ker_row      <= in_ker_row;
        cfg_ker_col      <= in_ker_col;
        cfg_num_channels <= in_num_channels;
      end
    end
  end

  // One-cycle start pulse in the first COMPUTE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_compute <= 1'b0;
    end else begin
      start_compute <= (state == ST_START);
    end
  end

  // Sticky flag for loader beats arriving after the kernel has closed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overflow <= 1'b0;
    end else if (job_start_p0) begin
      err_overflow <= 1'b0;
    end else if (wr_drop_p0) begin
      err_overflow <= 1'b1;
    end
  end

  // ---- stage START -> COMPUTE: size checks ----
  tensor_size_check #(
    .ADDR_WIDTH         (ADDR_WIDTH),
    .NUM_CHANNELS_WIDTH (NUM_CHANNELS_WIDTH)
  ) u_img_check (
    .clk          (clk),
    .rst          (rst),
    .clr          (job_start_p0),
    .check        (size_check_p0),
    .count        (img_cnt),
    .dim_row      (cfg_img_row),
    .dim_col      (cfg_img_col),
    .num_channels (cfg_num_channels),
    .mismatch     (img_mismatch)
  );

  tensor_size_check #(
    .ADDR_WIDTH         (ADDR_WIDTH),
    .NUM_CHANNELS_WIDTH (NUM_CHANNELS_WIDTH)
  ) u_ker_check (
    .clk          (clk),
    .rst          (rst),
    .clr          (job_start_p0),
    .check        (size_check_p0),
    .count        (ker_cnt),
    .dim_row      (cfg_ker_row),
    .dim_col      (cfg_ker_col),
    .num_channels (cfg_num_channels),
    .mismatch     (ker_mismatch)
  );

  assign err_size = img_mismatch | ker_mismatch;

endmodule

// File: tb/tb_sram_load_scheduler.sv
// Directed bench for sram_load_scheduler: a job-level reference model
// predicts every output each cycle; literal checks pin key moments.
module tb_sram_load_scheduler;
  import sram_load_scheduler_pkg::*;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int CW = 7;

  logic clk = 1'b0;
  logic rst;
  logic in_write_enable, in_last;
  logic [AW-1:0] in_write_address;
  logic signed [DW-1:0] in_write_data;
  logic [2:0] in_data_type;
  logic [AW-1:0] in_img_row, in_img_col, in_ker_row, in_ker_col;
  logic [CW-1:0] in_num_channels;
  logic cmp_rd_req, cmp_done;
  logic [2:0] cmp_rd_sel;
  logic [AW-1:0] cmp_rd_addr;
  logic cmp_rd_gnt, sram_en, sram_we, start_compute, busy, err_size, err_overflow;
  logic [2:0] sram_sel;
  logic [AW-1:0] sram_addr;
  logic signed [DW-1:0] sram_wdata;
  logic [AW-1:0] cfg_img_row, cfg_img_col, cfg_ker_row, cfg_ker_col;
  logic [CW-1:0] cfg_num_channels;

  int checks = 0;
  int errors = 0;
  int n_wr0 = 0;
  int n_wr1 = 0;

  sram_load_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CHANNELS_WIDTH(CW)) dut (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .in_write_enable(in_write_enable), .in_last(in_last),
    .in_write_address(in_write_address), .in_write_data(in_write_data),
    .in_data_type(in_data_type),
    .in_img_row(in_img_row), .in_img_col(in_img_col),
    .in_ker_row(in_ker_row), .in_ker_col(in_ker_col),
    .in_num_channels(in_num_channels),
    .cmp_rd_req(cmp_rd_req), .cmp_rd_sel(cmp_rd_sel), .cmp_rd_addr(cmp_rd_addr),
    .cmp_done(cmp_done), .cmp_rd_gnt(cmp_rd_gnt),
    .sram_en(sram_en), .sram_we(sram_we), .sram_sel(sram_sel),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .start_compute(start_compute), .busy(busy),
    .cfg_img_row(cfg_img_row), .cfg_img_col(cfg_img_col),
    .cfg_ker_row(cfg_ker_row), .cfg_ker_col(cfg_ker_col),
    .cfg_num_channels(cfg_num_channels),
    .err_size(err_size), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Job phase: 0 idle, 1 image, 2 kernel, 3 start cycle, 4 compute.
  int m_ph;
  int unsigned m_img, m_ker;
  int unsigned m_ir, m_ic, m_kr, m_kc, m_ch;
  logic e_en, e_we, e_gnt, e_start, e_esz, e_ovf;
  logic [2:0] e_sel;
  logic [AW-1:0] e_addr;
  logic signed [DW-1:0] e_wdata;

  function automatic int unsigned sat_inc(input int unsigned c);
    return (c >= (1 << AW)) ? (1 << AW) : c + 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= 0; m_img <= 0; m_ker <= 0;
      m_ir <= 0; m_ic <= 0; m_kr <= 0; m_kc <= 0; m_ch <= 0;
      e_en <= 0; e_we <= 0; e_gnt <= 0; e_start <= 0; e_esz <= 0; e_ovf <= 0;
      e_sel <= 0; e_addr <= 0; e_wdata <= 0;
    end else begin
      e_en <= 0; e_we <= 0; e_gnt <= 0;
      e_start <= (m_ph == 3);
      if (m_ph <= 2 && in_write_enable) begin
        e_en <= 1; e_we <= 1;
        e_sel <= in_data_type; e_addr <= in_write_address; e_wdata <= in_write_data;
      end
      if (m_ph == 0 && in_write_enable) begin
        m_img <= 1; m_ker <= 0; e_ovf <= 0; e_esz <= 0;
        if (in_last) begin m_ir <= in_img_row; m_ic <= in_img_col; m_ph <= 2; end
        else m_ph <= 1;
      end
      if (m_ph == 1 && in_write_enable) begin
        m_img <= sat_inc(m_img);
        if (in_last) begin m_ir <= in_img_row; m_ic <= in_img_col; m_ph <= 2; end
      end
      if (m_ph == 2 && in_write_enable) begin
        m_ker <= sat_inc(m_ker);
        if (in_last) begin
          m_kr <= in_ker_row; m_kc <= in_ker_col; m_ch <= in_num_channels; m_ph <= 3;
        end
      end
      if (m_ph >= 3 && in_write_enable) e_ovf <= 1;
      if (m_ph == 3) begin
        m_ph <= 4;
        if (longint'(m_img) != longint'(m_ir) * m_ic * m_ch ||
            longint'(m_ker) != longint'(m_kr) * m_kc * m_ch) e_esz <= 1;
      end
      if (m_ph == 4) begin
        if (cmp_rd_req) begin
          e_en <= 1; e_gnt <= 1; e_sel <= cmp_rd_sel; e_addr <= cmp_rd_addr;
        end
        if (cmp_done) m_ph <= 0;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    check("sram_en", sram_en, e_en);
    check("sram_we", sram_we, e_we);
    check("cmp_rd_gnt", cmp_rd_gnt, e_gnt);
    check("start_compute", start_compute, e_start);
    check("busy", busy, (m_ph != 0));
    check("err_size", err_size, e_esz);
    check("err_overflow", err_overflow, e_ovf);
    check("cfg_img_row", cfg_img_row, m_ir);
    check("cfg_img_col", cfg_img_col, m_ic);
    check("cfg_ker_row", cfg_ker_row, m_kr);
    check("cfg_ker_col", cfg_ker_col, m_kc);
    check("cfg_num_channels", cfg_num_channels, m_ch);
    if (e_en) begin
      check("sram_sel", sram_sel, e_sel);
      check("sram_addr", sram_addr, e_addr);
      if (e_we) check("sram_wdata", sram_wdata, e_wdata);
    end
    if (sram_en && sram_we) begin
      if (sram_sel == GEMM0_SRAM_IDX) n_wr0++;
      else if (sram_sel == GEMM1_SRAM_IDX) n_wr1++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_dims(input int ir, input int ic, input int kr, input int kc, input int ch);
    in_img_row = AW'(ir); in_img_col = AW'(ic);
    in_ker_row = AW'(kr); in_ker_col = AW'(kc); in_num_channels = CW'(ch);
  endtask

  task automatic beat(input int addr, input int data, input logic [2:0] sel, input bit last);
    in_write_enable = 1'b1; in_last = last;
    in_write_address = AW'(addr); in_write_data = DW'(data); in_data_type = sel;
    @(posedge clk); #1;
    in_write_enable = 1'b0; in_last = 1'b0;
  endtask

  task automatic load(input int n, input int base, input logic [2:0] sel, input int seed);
    for (int i = 0; i < n; i++) beat(base + i, seed - 37 * i, sel, (i == n - 1));
  endtask

  initial begin
    rst = 1'b1;
    in_write_enable = 0; in_last = 0; in_write_address = 0; in_write_data = 0; in_data_type = 0;
    set_dims(0, 0, 0, 0, 0);
    cmp_rd_req = 0; cmp_rd_sel = 0; cmp_rd_addr = 0; cmp_done = 0;
    cyc(3);
    check("reset sram_en", sram_en, 0);
    check("reset busy", busy, 0);
    check("reset start", start_compute, 0);
    check("reset cfg_img_row", cfg_img_row, 0);
    check("reset err_size", err_size, 0);
    rst = 1'b0;
    cyc(1);

    // Job 1: 2x2x1 image and kernel, sizes match.
    set_dims(2, 2, 2, 2, 1);
    beat(0, -3, GEMM0_SRAM_IDX, 0);
    beat(1, 5, GEMM0_SRAM_IDX, 0);
    beat(2, 127, GEMM0_SRAM_IDX, 0);
    beat(3, -128, GEMM0_SRAM_IDX, 1);
    load(4, 16, GEMM1_SRAM_IDX, 100);
    check("T+1 cfg_ker_row", cfg_ker_row, 2);
    check("T+1 start", start_compute, 0);
    cyc(1);
    check("T+2 start", start_compute, 1);
    check("T+2 err_size", err_size, 0);
    cyc(1);
    check("T+3 start", start_compute, 0);
    check("gemm0 writes", n_wr0, 4);
    check("gemm1 writes", n_wr1, 4);

    // Read in COMPUTE.
    cmp_rd_req = 1; cmp_rd_sel = GEMM1_SRAM_IDX; cmp_rd_addr = 5;
    cyc(1);
    cmp_rd_req = 0;
    check("rd sram_en", sram_en, 1);
    check("rd sram_we", sram_we, 0);
    check("rd sram_addr", sram_addr, 5);
    check("rd gnt", cmp_rd_gnt, 1);

    // Loader beat in COMPUTE is dropped.
    beat(7, 9, GEMM0_SRAM_IDX, 0);
    check("ovf sram_en", sram_en, 0);
    check("ovf flag", err_overflow, 1);
    cmp_done = 1;
    cyc(1);
    cmp_done = 0;
    check("done busy", busy, 0);

    // Job 2: image declared 3x3x1 but only 8 beats.
    set_dims(3, 3, 2, 2, 1);
    beat(0, 11, GEMM0_SRAM_IDX, 0);
    check("job2 ovf cleared", err_overflow, 0);
    cmp_rd_req = 1; cmp_rd_sel = GEMM1_SRAM_IDX; cmp_rd_addr = 5;
    beat(1, 12, GEMM0_SRAM_IDX, 0);
    cmp_rd_req = 0;
    check("load rd gnt", cmp_rd_gnt, 0);
    check("load write we", sram_we, 1);
    for (int i = 2; i < 8; i++) beat(i, i * 3, GEMM0_SRAM_IDX, (i == 7));
    load(4, 32, GEMM1_SRAM_IDX, -50);
    cyc(1);
    check("job2 err_size", err_size, 1);
    check("job2 start", start_compute, 1);
    cmp_done = 1; cmp_rd_req = 1; cmp_rd_sel = GEMM0_SRAM_IDX; cmp_rd_addr = 9;
    cyc(1);
    cmp_done = 0; cmp_rd_req = 0;
    check("done+rd gnt", cmp_rd_gnt, 1);
    check("done+rd addr", sram_addr, 9);
    check("done+rd busy", busy, 0);

    // Job 3: single-beat image, then reset in the middle of the kernel.
    set_dims(1, 1, 2, 2, 1);
    beat(0, 42, GEMM0_SRAM_IDX, 1);
    check("job3 err_size cleared", err_size, 0);
    check("job3 busy", busy, 1);
    beat(64, 1, GEMM1_SRAM_IDX, 0);
    beat(65, 2, GEMM1_SRAM_IDX, 0);
    rst = 1'b1;
    #1;
    check("midrst sram_en", sram_en, 0);
    check("midrst busy", busy, 0);
    check("midrst cfg_img_row", cfg_img_row, 0);
    check("midrst start", start_compute, 0);
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // Job 4: clean 2x1x2 image, 1x1x2 kernel after the reset.
    set_dims(2, 1, 1, 1, 2);
    load(4, 100, GEMM0_SRAM_IDX, 7);
    load(2, 200, GEMM1_SRAM_IDX, -9);
    cyc(1);
    check("job4 start", start_compute, 1);
    check("job4 err_size", err_size, 0);
    check("job4 cfg_num_channels", cfg_num_channels, 2);
    cmp_done = 1;
    cyc(1);
    cmp_done = 0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
